// File: rtl/lc3b_types.sv
// lc3b_types: shared geometry types for the LC-3b cache datapath.
//   lc3b_burst        - one 256-bit cache line (word k = bits [16k+15:16k])
//   lc3b_word         - 16-bit machine word / byte address
//   lc3b_cache_offset - 5-bit byte offset within a line
//   lc3b_word_mask    - one bit per 16-bit word of a line
//   LINE_WORDS        - number of 16-bit words in a line
package lc3b_types;

  typedef logic [255:0] lc3b_burst;
  typedef logic [15:0]  lc3b_word;
  typedef logic [4:0]   lc3b_cache_offset;
  typedef logic [15:0]  lc3b_word_mask;

  localparam int LINE_WORDS = 16;

endpackage

// File: rtl/line_serializer_if.sv
// line_serializer_if: load-side and word-stream signals of line_serializer.
//   load/line_in/base_addr  - capture request (honoured only while idle)
//   word_mask               - per-word emit mask (only with LINE_SER_MASK_EN)
//   busy                    - a line is being streamed or is finishing
//   out_valid/out_ready     - word stream handshake
//   out_data/out_addr/out_offset - current word, its byte address and offset
//   done                    - one-cycle pulse after the last word transfers
//   dbg_state               - serializer FSM state (IDLE=0, SEND=1, DONE=2)
//
// Handshake: a word transfers on a rising edge where out_valid & out_ready
// are both high. Once out_valid is high, out_data/out_addr/out_offset stay
// stable and out_valid stays high until that transfer (reset excepted).
// out_ready while out_valid is low has no effect; out_valid never depends
// combinationally on out_ready.
interface line_serializer_if;
  import lc3b_types::*;

  logic             load;
  lc3b_burst        line_in;
  lc3b_word         base_addr;
`ifdef LINE_SER_MASK_EN
  lc3b_word_mask    word_mask;
`endif
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  lc3b_word         out_data;
  lc3b_word         out_addr;
  lc3b_cache_offset out_offset;
  logic             done;
  logic [1:0]       dbg_state;

`ifdef LINE_SER_MASK_EN
  modport master (
    input  load, line_in, base_addr, word_mask, out_ready,
    output busy, out_valid, out_data, out_addr, out_offset, done, dbg_state
  );
  modport slave (
    output load, line_in, base_addr, word_mask, out_ready,
    input  busy, out_valid, out_data, out_addr, out_offset, done, dbg_state
  );
`else
  modport master (
    input  load, line_in, base_addr, out_ready,
    output busy, out_valid, out_data, out_addr, out_offset, done, dbg_state
  );
  modport slave (
    output load, line_in, base_addr, out_ready,
    input  busy, out_valid, out_data, out_addr, out_offset, done, dbg_state
  );
`endif

endinterface

// File: rtl/next_word_sel.sv
// next_word_sel: combinational priority finder over a 16-bit word mask.
//   mask      in  16 - words still eligible for emission
//   idx       in  4  - current word index
//   next_idx  out 4  - lowest set bit strictly above idx (0 if none)
//   first_idx out 4  - lowest set bit of mask (0 if mask is zero)
//   none      out 1  - no set bit strictly above idx
// Only present in builds with LINE_SER_MASK_EN defined.
`ifdef LINE_SER_MASK_EN
module next_word_sel (
  input  logic [15:0] mask,
  input  logic [3:0]  idx,
  output logic [3:0]  next_idx,
  output logic [3:0]  first_idx,
  output logic        none
);

  // Scan from the top down so the lowest matching bit is written last.
  always_comb begin
    next_idx  = '0;
    first_idx = '0;
    none      = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        first_idx = 4'(i);
        if (i > int'(idx)) begin
          next_idx = 4'(i);
          none     = 1'b0;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/line_serializer.sv
// line_serializer: captures one 256-bit cache line and streams it out as
// sixteen 16-bit words, lowest offset first, over a valid/ready handshake.
//   clk  in  - rising-edge clock
//   rst  in  - synchronous active-high reset
//   bus  master modport of line_serializer_if (load side + word stream)
// Optional feature: define LINE_SER_MASK_EN to add word_mask, which skips
// masked-off words at no cycle cost.
module line_serializer
  import lc3b_types::*;
(
  input  logic              clk,
  input  logic              rst,
  line_serializer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  lc3b_burst   line_q, line_d;
  logic [10:0] base_q, base_d;

  logic        last_beat;     // current word is the final one of the line
  logic [3:0]  next_idx;      // index to move to after a transfer
  logic [3:0]  load_idx;      // first index to emit after a load
  logic        load_to_done;  // load carries nothing to emit

  // Low address bits are implied by idx and never stored.
  logic unused_base_bits;
  assign unused_base_bits = ^bus.base_addr[4:0];

`ifdef LINE_SER_MASK_EN
  lc3b_word_mask mask_q, mask_d, mask_sel;
  logic [3:0]    sel_next, sel_first;
  logic          sel_none;

  // While idle the incoming mask is examined so the first word is known at
  // the load edge; afterwards the captured mask drives the search.
  assign mask_sel = (state_q == S_IDLE) ? bus.word_mask : mask_q;

  next_word_sel u_next_word_sel (
    .mask      (mask_sel),
    .idx       (idx_q),
    .next_idx  (sel_next),
    .first_idx (sel_first),
    .none      (sel_none)
  );

  assign last_beat    = sel_none;
  assign next_idx     = sel_next;
  assign load_idx     = sel_first;
  assign load_to_done = (bus.word_mask == '0);

  always_comb begin
    mask_d = mask_q;
    if ((state_q == S_IDLE) && bus.load) begin
      mask_d = bus.word_mask;
    end
  end
`else
  assign last_beat    = (idx_q == 4'(LINE_WORDS - 1));
  assign next_idx     = idx_q + 4'd1;
  assign load_idx     = 4'd0;
  assign load_to_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    line_d  = line_q;
    base_d  = base_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          line_d  = bus.line_in;
          base_d  = bus.base_addr[15:5];
          idx_d   = load_idx;
          state_d = load_to_done ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        // out_valid is high throughout SEND, so out_ready alone marks a beat.
        if (bus.out_ready) begin
          if (last_beat) begin
            state_d = S_DONE;
          end else begin
            idx_d = next_idx;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      line_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      base_q  <= base_d;
    end
  end

`ifdef LINE_SER_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`endif

  // All outputs come from registered state, never from out_ready.
  assign bus.busy       = (state_q == S_SEND) || (state_q == S_DONE);
  assign bus.out_valid  = (state_q == S_SEND);
  assign bus.done       = (state_q == S_DONE);
  assign bus.out_data   = line_q[{idx_q, 4'b0000} +: 16];
  assign bus.out_addr   = {base_q, idx_q, 1'b0};
  assign bus.out_offset = {idx_q, 1'b0};
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_line_serializer.sv
// tb_line_serializer: directed self-checking bench for line_serializer.
// Mask-specific vectors are included when LINE_SER_MASK_EN is defined.
module tb_line_serializer;

  logic clk;
  logic rst;

  line_serializer_if bus ();

  line_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected beats: {out_addr, out_data}
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [15:0] first);
    logic [255:0] l;
    for (int k = 0; k < 16; k++) begin
      l[16*k +: 16] = first + 16'(k);
    end
    return l;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [255:0] line, input logic [15:0] base, input logic [15:0] mask);
    @(negedge clk);
    bus.load      = 1'b1;
    bus.line_in   = line;
    bus.base_addr = base;
`ifdef LINE_SER_MASK_EN
    bus.word_mask = mask;
`else
    if (mask != 16'hFFFF) $display("note: mask ignored in this build");
`endif
    @(posedge clk);
  endtask

  // Called right after the load edge. Streams the line, optionally stalling
  // on one word and pulsing a stray load during another, then checks done.
  task automatic run_line(input logic [255:0] line, input logic [15:0] base,
                          input logic [15:0] mask, input int stall_word,
                          input int stall_cycles, input int inject_word,
                          input int exp_done_cyc);
    int          cyc;
    logic [31:0] beat;
    cyc = 1;
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      if (mask[k]) exp_q.push_back({(base & 16'hFFE0) | 16'(k * 2), line[16*k +: 16]});
    end
    for (int k = 0; k < 16; k++) begin
      if (!mask[k]) continue;
      beat = exp_q.pop_front();
      if (k == stall_word) begin
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clk);
          bus.load      = 1'b0;
          bus.out_ready = 1'b0;
          check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
          check_eq("stall_data",  32'(bus.out_data),  32'(beat[15:0]));
          check_eq("stall_addr",  32'(bus.out_addr),  32'(beat[31:16]));
          @(posedge clk);
          cyc++;
        end
      end
      @(negedge clk);
      bus.load      = 1'b0;
      bus.out_ready = 1'b1;
      if (k == inject_word) begin
        bus.load      = 1'b1;
        bus.line_in   = ~line;
        bus.base_addr = ~base;
      end
      check_eq("beat_valid",  32'(bus.out_valid),  32'd1);
      check_eq("beat_done",   32'(bus.done),       32'd0);
      check_eq("beat_data",   32'(bus.out_data),   32'(beat[15:0]));
      check_eq("beat_addr",   32'(bus.out_addr),   32'(beat[31:16]));
      check_eq("beat_offset", 32'(bus.out_offset), 32'(k * 2));
      check_eq("beat_state",  32'(bus.dbg_state),  32'd1);
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.load = 1'b0;
    check_eq("done_pulse", 32'(bus.done),      32'd1);
    check_eq("done_valid", 32'(bus.out_valid), 32'd0);
    check_eq("done_busy",  32'(bus.busy),      32'd1);
    check_eq("done_state", 32'(bus.dbg_state), 32'd2);
    check_eq("done_cycle", 32'(cyc),           32'(exp_done_cyc));
    check_eq("beats_left", 32'(exp_q.size()),  32'd0);
    @(negedge clk);
    check_eq("idle_done",  32'(bus.done),      32'd0);
    check_eq("idle_busy",  32'(bus.busy),      32'd0);
    check_eq("idle_valid", 32'(bus.out_valid), 32'd0);
    check_eq("idle_state", 32'(bus.dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] line_a, line_b;
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.line_in   = '0;
    bus.base_addr = '0;
    bus.out_ready = 1'b1;
`ifdef LINE_SER_MASK_EN
    bus.word_mask = '0;
`endif
    line_a = make_line(16'hA000);
    line_b = make_line(16'h5100);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy",   32'(bus.busy),       32'd0);
    check_eq("rst_valid",  32'(bus.out_valid),  32'd0);
    check_eq("rst_done",   32'(bus.done),       32'd0);
    check_eq("rst_data",   32'(bus.out_data),   32'd0);
    check_eq("rst_addr",   32'(bus.out_addr),   32'd0);
    check_eq("rst_offset", 32'(bus.out_offset), 32'd0);
    check_eq("rst_state",  32'(bus.dbg_state),  32'd0);

    // ready high throughout: A000..A00F at 1220..123E, done at t+17
    do_load(line_a, 16'h1234, 16'hFFFF);
    run_line(line_a, 16'h1234, 16'hFFFF, -1, 0, -1, 17);

    // three stall cycles on word 5: done at t+20
    do_load(line_b, 16'hBEEF, 16'hFFFF);
    run_line(line_b, 16'hBEEF, 16'hFFFF, 5, 3, -1, 20);

    // stray load during SEND with a different line is ignored
    do_load(line_a, 16'h8000, 16'hFFFF);
    run_line(line_a, 16'h8000, 16'hFFFF, -1, 0, 3, 17);

    // reset after word 7 transfers: partial line dropped, no done
    do_load(line_b, 16'h4420, 16'hFFFF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.load      = 1'b0;
      bus.out_ready = 1'b1;
      check_eq("part_data", 32'(bus.out_data), 32'(16'h5100 + 16'(k)));
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("part_word8", 32'(bus.out_offset), 32'd16);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_busy",  32'(bus.busy),      32'd0);
    check_eq("abort_done",  32'(bus.done),      32'd0);
    check_eq("abort_data",  32'(bus.out_data),  32'd0);
    check_eq("abort_state", 32'(bus.dbg_state), 32'd0);
    @(negedge clk);
    check_eq("abort_done2", 32'(bus.done),      32'd0);
    check_eq("abort_idle",  32'(bus.out_valid), 32'd0);
    do_load(line_a, 16'h0F00, 16'hFFFF);
    run_line(line_a, 16'h0F00, 16'hFFFF, -1, 0, -1, 17);

`ifdef LINE_SER_MASK_EN
    // only words 0 and 15: offsets 0x00 and 0x1E, done at t+3
    do_load(make_line(16'hC000), 16'h0040, 16'h8001);
    run_line(make_line(16'hC000), 16'h0040, 16'h8001, -1, 0, -1, 3);
    // sparse mask with a stall on word 9
    do_load(make_line(16'hD000), 16'h7777, 16'h0A24);
    run_line(make_line(16'hD000), 16'h7777, 16'h0A24, 9, 2, -1, 7);
    // empty mask: done at t+1, no beats
    do_load(make_line(16'hE000), 16'h2000, 16'h0000);
    run_line(make_line(16'hE000), 16'h2000, 16'h0000, -1, 0, -1, 1);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
